// File: rtl/sim_mem_pkg.sv
// rtl/sim_mem_pkg.sv - shared constants, response entry type and byte-mask helper for sim_mem_responder
package sim_mem_pkg;

   localparam int SM_DATA_WIDTH    = 64;
   localparam int SM_LOGSIZE_WIDTH = 3;
   localparam int SM_NB            = SM_DATA_WIDTH / 8;
   localparam int SM_BO            = $clog2(SM_NB);
   localparam int SM_CNT_WIDTH     = 8;

   typedef struct packed {
      logic                        is_store;
      logic [SM_LOGSIZE_WIDTH-1:0] size;
      logic [SM_DATA_WIDTH-1:0]    data;
      logic [SM_CNT_WIDTH-1:0]     cnt;
   } resp_entry_t;

   // Offset is first aligned down to the access size, so a misaligned
   // sub-word request touches the naturally aligned container.
   function automatic logic [SM_NB-1:0] byte_mask(
      input logic [SM_BO-1:0]            offset,
      input logic [SM_LOGSIZE_WIDTH-1:0] size
   );
      int unsigned       nbytes;
      logic [SM_BO-1:0]  base;
      logic [SM_NB-1:0]  ones;
      if (int'(size) >= SM_BO) return '1;
      nbytes = 32'd1 << size;
      base   = offset & ~SM_BO'(nbytes - 32'd1);
      ones   = SM_NB'((64'd1 << nbytes) - 64'd1);
      return ones << base;
   endfunction

endpackage

// File: rtl/sim_mem_resp_queue.sv
// rtl/sim_mem_resp_queue.sv - per-lane circular response queue with saturating per-entry countdown
module sim_mem_resp_queue
   import sim_mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  resp_entry_t entry,
   input  logic        take,
   output logic        ready,
   output resp_entry_t head,
   output logic        full,
   output logic        busy_next
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   resp_entry_t    slots [DEPTH];
   logic [PW-1:0]  head_ptr;
   logic [PW-1:0]  tail_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  next_count;
   logic           pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head      = slots[head_ptr];
   assign ready     = (count != '0) && (slots[head_ptr].cnt == '0);
   assign full      = (count == CW'(DEPTH));
   assign pop       = ready & take;
   assign busy_next = (next_count != '0);

   always_comb begin
      next_count = count;
      if (push && !pop)
         next_count = count + CW'(1);
      else if (pop && !push)
         next_count = count - CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++)
            slots[i].cnt <= '0;
      end else begin
         // Every slot ages each cycle; a stalled head simply sits at zero.
         for (int i = 0; i < DEPTH; i++)
            if (slots[i].cnt != '0)
               slots[i].cnt <= slots[i].cnt - SM_CNT_WIDTH'(1);
         if (push) begin
            slots[tail_ptr] <= entry;
            tail_ptr        <= bump(tail_ptr);
         end
         if (pop)
            head_ptr <= bump(head_ptr);
         count <= next_count;
      end
   end

endmodule

// File: rtl/sim_mem_responder.sv
// rtl/sim_mem_responder.sv - multi-lane a/d memory responder; SIMMEM_RESP_RANDOM_STALL_EN adds LFSR a_ready stalls
module sim_mem_responder
   import sim_mem_pkg::*;
#(
   parameter int NUM_LANES     = 4,
   parameter int DATA_WIDTH    = SM_DATA_WIDTH,
   parameter int LOGSIZE_WIDTH = SM_LOGSIZE_WIDTH,
   parameter int MEM_ADDR_BITS = 10,
   parameter int LATENCY       = 4,
   parameter int QUEUE_DEPTH   = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   output logic [NUM_LANES-1:0]               a_ready,
   input  logic [NUM_LANES-1:0]               a_valid,
   input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
   input  logic [NUM_LANES-1:0]               a_is_store,
   input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
   input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
   input  logic [NUM_LANES-1:0]               d_ready,
   output logic [NUM_LANES-1:0]               d_valid,
   output logic [NUM_LANES-1:0]               d_is_store,
   output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
   output logic [DATA_WIDTH*NUM_LANES-1:0]    d_data,
   output logic                               inflight
);

   logic [DATA_WIDTH-1:0]    ram [2**MEM_ADDR_BITS];
   logic [NUM_LANES-1:0]     a_fire;
   logic [NUM_LANES-1:0]     pass;
   logic [NUM_LANES-1:0]     full;
   logic [NUM_LANES-1:0]     busy_next;
   logic [MEM_ADDR_BITS-1:0] word_idx [NUM_LANES];
   logic [SM_NB-1:0]         mask     [NUM_LANES];
   resp_entry_t              entry    [NUM_LANES];
   resp_entry_t              head     [NUM_LANES];

`ifdef SIMMEM_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clock) begin
      if (reset)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
`endif

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [DATA_WIDTH-1:0] addr;
      logic                  unused_lane;

      assign addr        = a_address[DATA_WIDTH*g +: DATA_WIDTH];
      assign word_idx[g] = addr[MEM_ADDR_BITS+SM_BO-1:SM_BO];
      assign mask[g]     = byte_mask(addr[SM_BO-1:0], a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH]);
      assign unused_lane = ^{addr[DATA_WIDTH-1:MEM_ADDR_BITS+SM_BO], head[g].cnt};

`ifdef SIMMEM_RESP_RANDOM_STALL_EN
      assign pass[g] = lfsr[g % 16];
`else
      assign pass[g] = 1'b1;
`endif

      assign a_ready[g] = ~reset & ~full[g] & pass[g];
      assign a_fire[g]  = a_valid[g] & a_ready[g];

      // The RAM read here is combinational, so a load sees the word as it
      // stood before any store committed on this same edge.
      assign entry[g] = '{
         is_store: a_is_store[g],
         size:     a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH],
         data:     a_is_store[g] ? '0 : ram[word_idx[g]],
         cnt:      SM_CNT_WIDTH'(LATENCY - 1)
      };

      sim_mem_resp_queue #(
         .DEPTH (QUEUE_DEPTH)
      ) u_queue (
         .clock     (clock),
         .reset     (reset),
         .push      (a_fire[g]),
         .entry     (entry[g]),
         .take      (d_ready[g]),
         .ready     (d_valid[g]),
         .head      (head[g]),
         .full      (full[g]),
         .busy_next (busy_next[g])
      );

      assign d_is_store[g]                             = d_valid[g] & head[g].is_store;
      assign d_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH]  = d_valid[g] ? head[g].size : '0;
      assign d_data[DATA_WIDTH*g +: DATA_WIDTH]        = d_valid[g] ? head[g].data : '0;
   end

   // Later lanes overwrite earlier ones within the loop, so the highest
   // lane wins any byte stored by several lanes on one edge.
   always_ff @(posedge clock) begin
      for (int g = 0; g < NUM_LANES; g++)
         if (a_fire[g] && a_is_store[g])
            for (int b = 0; b < SM_NB; b++)
               if (mask[g][b])
                  ram[word_idx[g]][8*b +: 8] <= a_data[DATA_WIDTH*g + 8*b +: 8];
   end

   always_ff @(posedge clock) begin
      if (reset)
         inflight <= 1'b0;
      else
         inflight <= |busy_next;
   end

endmodule

// File: tb/tb_sim_mem_responder.sv
// tb/tb_sim_mem_responder.sv - scoreboard bench for sim_mem_responder with directed vectors
module tb_sim_mem_responder;

   localparam int NL  = 4;
   localparam int DW  = 64;
   localparam int SW  = 3;
   localparam int LAT = 4;

   logic              clock;
   logic              reset;
   logic [NL-1:0]     a_ready, a_valid, a_is_store, d_ready, d_valid, d_is_store;
   logic [DW*NL-1:0]  a_address, a_data, d_data;
   logic [SW*NL-1:0]  a_size, d_size;
   logic              inflight;

   typedef struct packed {
      logic          st;
      logic [SW-1:0] sz;
      logic [DW-1:0] data;
      logic [31:0]   due;
      logic          exact;
   } exp_t;

   exp_t sb [NL][$];
   exp_t pend [NL];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;

   sim_mem_responder dut (
      .clock      (clock),
      .reset      (reset),
      .a_ready    (a_ready),
      .a_valid    (a_valid),
      .a_address  (a_address),
      .a_is_store (a_is_store),
      .a_size     (a_size),
      .a_data     (a_data),
      .d_ready    (d_ready),
      .d_valid    (d_valid),
      .d_is_store (d_is_store),
      .d_size     (d_size),
      .d_data     (d_data),
      .inflight   (inflight)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic set_lane(input int g, input logic st, input logic [63:0] addr,
                           input logic [2:0] sz, input logic [63:0] data, input logic [63:0] exp_load);
      a_valid[g]             = 1'b1;
      a_is_store[g]          = st;
      a_address[DW*g +: DW]  = addr;
      a_size[SW*g +: SW]     = sz;
      a_data[DW*g +: DW]     = data;
      pend[g] = '{st: st, sz: sz, data: (st ? 64'd0 : exp_load), due: 32'd0, exact: 1'b0};
   endtask

   task automatic step(output logic [NL-1:0] acc);
      @(negedge clock);
      acc = a_valid & a_ready;
      for (int g = 0; g < NL; g++) begin
         if (acc[g]) begin
            exp_t e;
            e       = pend[g];
            e.due   = 32'(cyc + LAT);
            e.exact = d_ready[g];
            sb[g].push_back(e);
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic send(input int g, input logic st, input logic [63:0] addr,
                       input logic [2:0] sz, input logic [63:0] data, input logic [63:0] exp_load);
      logic [NL-1:0] acc;
      int tries;
      set_lane(g, st, addr, sz, data, exp_load);
      tries = 0;
      acc = '0;
      while (!acc[g] && tries < 20) begin
         step(acc);
         tries++;
      end
      if (!acc[g]) begin
         checks++;
         $display("FAIL send_timeout lane %0d: got no accept, expected accept within 20 cycles", g);
      end
      a_valid[g] = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Response monitor: pops the lane scoreboard on every d-fire.
   initial begin
      forever begin
         @(negedge clock);
         for (int g = 0; g < NL; g++) begin
            if (d_valid[g] === 1'b1 && d_ready[g] === 1'b1) begin
               exp_t e;
               if (sb[g].size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_resp lane %0d: got d_valid=1, expected no response", g);
               end else begin
                  e = sb[g].pop_front();
                  chk($sformatf("d_data_l%0d", g), d_data[DW*g +: DW], e.data);
                  chk($sformatf("d_size_l%0d", g), 64'(d_size[SW*g +: SW]), 64'(e.sz));
                  chk($sformatf("d_is_store_l%0d", g), 64'(d_is_store[g]), 64'(e.st));
                  if (e.exact)
                     chk($sformatf("latency_l%0d", g), 64'(cyc), 64'(e.due));
               end
            end
         end
      end
   end

   logic [63:0] fa [5];
   logic [63:0] fe [5];

   initial begin
      logic [NL-1:0] acc;
      int pending;
      a_valid = '0; a_is_store = '0; a_address = '0; a_size = '0; a_data = '0;
      d_ready = '1;
      reset   = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_a_ready", 64'(a_ready), 64'd0);
      chk("reset_d_valid", 64'(d_valid), 64'd0);
      chk("reset_d_data", d_data[63:0], 64'd0);
      chk("reset_d_size", 64'(d_size), 64'd0);
      chk("reset_d_is_store", 64'(d_is_store), 64'd0);
      chk("reset_inflight", 64'(inflight), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Full-word store then load, plus sub-word stores with offset truncation.
      send(0, 1'b1, 64'h40, 3'd3, 64'h1122334455667788, 64'd0);
      send(0, 1'b0, 64'h40, 3'd3, 64'd0, 64'h1122334455667788);
      send(0, 1'b1, 64'h42, 3'd0, 64'h0000_0000_00AB_0000, 64'd0);
      send(0, 1'b0, 64'h40, 3'd3, 64'd0, 64'h1122334455AB7788);
      send(0, 1'b1, 64'h45, 3'd1, 64'h0000_BEEF_0000_0000, 64'd0);
      send(0, 1'b0, 64'h40, 3'd3, 64'd0, 64'h1122BEEF55AB7788);
      wait_cycles(8);

      // Same-cycle collision on word 0x80 with a read-before-write load.
      send(1, 1'b1, 64'h80, 3'd3, 64'hDEADBEEFCAFEF00D, 64'd0);
      set_lane(0, 1'b1, 64'h80, 3'd3, 64'h1, 64'd0);
      set_lane(3, 1'b1, 64'h80, 3'd3, 64'h3, 64'd0);
      set_lane(2, 1'b0, 64'h80, 3'd3, 64'd0, 64'hDEADBEEFCAFEF00D);
      step(acc);
      chk("collide_accept", 64'(acc), 64'hD);
      a_valid = '0;
      send(2, 1'b0, 64'h80, 3'd3, 64'd0, 64'h3);
      wait_cycles(8);

      // Queue full on lane1, including an address that wraps onto word 8.
      fa = '{64'h40, 64'h80, 64'h2040, 64'h80, 64'h40};
      fe = '{64'h1122BEEF55AB7788, 64'h3, 64'h1122BEEF55AB7788, 64'h3, 64'h1122BEEF55AB7788};
      d_ready[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_lane(1, 1'b0, fa[i], 3'd3, 64'd0, fe[i]);
         step(acc);
         chk($sformatf("full_accept_%0d", i), 64'(acc[1]), (i < 4) ? 64'd1 : 64'd0);
      end
      a_valid = '0;
      wait_cycles(6);
      @(negedge clock);
      chk("full_a_ready", 64'(a_ready[1]), 64'd0);
      @(posedge clock); #1;
      d_ready[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk($sformatf("drain_valid_%0d", k), 64'(d_valid[1]), (k < 4) ? 64'd1 : 64'd0);
         if (k == 0) chk("drain_a_ready_first", 64'(a_ready[1]), 64'd0);
         if (k == 1) chk("drain_a_ready_after", 64'(a_ready[1]), 64'd1);
         @(posedge clock); #1;
      end
      wait_cycles(4);

      // Reset while three loads are queued on lane2.
      for (int i = 0; i < 3; i++) begin
         set_lane(2, 1'b0, 64'h80, 3'd3, 64'd0, 64'h3);
         step(acc);
         chk($sformatf("rst_accept_%0d", i), 64'(acc[2]), 64'd1);
      end
      a_valid = '0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      sb[2].delete();
      @(negedge clock);
      chk("rst_inflight", 64'(inflight), 64'd0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rst_no_valid_%0d", k), 64'(d_valid), 64'd0);
         @(negedge clock);
      end
      @(posedge clock); #1;

      // inflight window around a single load.
      @(negedge clock);
      chk("inflight_idle", 64'(inflight), 64'd0);
      @(posedge clock); #1;
      set_lane(0, 1'b0, 64'h80, 3'd3, 64'd0, 64'h3);
      step(acc);
      a_valid = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         chk($sformatf("inflight_%0d", k), 64'(inflight), (k <= 4) ? 64'd1 : 64'd0);
         @(posedge clock); #1;
      end

      pending = 1;
      for (int t = 0; t < 40 && pending != 0; t++) begin
         pending = 0;
         for (int g = 0; g < NL; g++) pending += sb[g].size();
         if (pending != 0) wait_cycles(1);
      end
      chk("scoreboard_drained", 64'(pending), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sim_mem_responder.md
Name: sim_mem_responder

Overview:
- Synthesizable multi-lane memory responder; the far end of the per-lane a/d request-response interface driven by the DPI traffic emulator.
- Accepts a-channel load/store requests on each lane and applies them to a shared word-addressed backing RAM.
- Returns d-channel responses after a fixed latency through per-lane response queues.
- Drives the `inflight` indication the emulator uses to decide completion.

Parameters:
- NUM_LANES, 4, number of independent request/response lanes.
- DATA_WIDTH, 64, address and data width per lane, in bits; a multiple of 8.
- LOGSIZE_WIDTH, 3, width of each size field; size is log2(bytes).
- MEM_ADDR_BITS, 10, log2 of the backing RAM depth in words.
- LATENCY, 4, minimum cycles from request accept to response valid; must be >= 1.
- QUEUE_DEPTH, 4, response entries per lane; must be >= 1.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- a_ready  out  NUM_LANES  per-lane request accept.
- a_valid  in  NUM_LANES  per-lane request valid.
- a_address  in  DATA_WIDTH*NUM_LANES  byte address; lane g occupies bits [DATA_WIDTH*g +: DATA_WIDTH].
- a_is_store  in  NUM_LANES  1 = store, 0 = load.
- a_size  in  LOGSIZE_WIDTH*NUM_LANES  log2 of access size in bytes.
- a_data  in  DATA_WIDTH*NUM_LANES  store data, byte-lane aligned to the address.
- d_ready  in  NUM_LANES  per-lane response accept.
- d_valid  out  NUM_LANES  per-lane response valid.
- d_is_store  out  NUM_LANES  echo of a_is_store.
- d_size  out  LOGSIZE_WIDTH*NUM_LANES  echo of a_size.
- d_data  out  DATA_WIDTH*NUM_LANES  load data (full word); 0 for stores.
- inflight  out  1  any lane queue non-empty.

Behaviour:
- Reset: synchronous, active-high. All queues empty, all countdowns 0. RAM contents are not reset.
- Reset values: a_ready = 0 while reset is high; d_valid = 0; d_is_store, d_size and d_data = 0; inflight = 0.
- Reset mid-operation: all queued responses are dropped; no d_valid appears after reset deasserts.
- Handshakes: a-fire = a_valid & a_ready; d-fire = d_valid & d_ready, both per lane.
- a_ready[g] = (count[g] < QUEUE_DEPTH). It depends only on registered count; there is no same-cycle pass-through. A full queue with a simultaneous d-fire still shows a_ready = 0 that cycle.
- Word index = a_address[MEM_ADDR_BITS+BO-1 : BO], where BO = log2(DATA_WIDTH/8). Upper address bits are ignored (address wraps modulo RAM size).
- Byte mask: 2^size bytes starting at byte offset a_address[BO-1:0], with the offset truncated to size alignment.
  - size >= BO selects the whole word.
  - A store writes only the masked bytes of a_data.
- Loads read the RAM in the accept cycle and see the state before that cycle's writes (read-before-write). The full word is queued as d_data.
- Same-cycle store collision on one word: stores are applied in ascending lane order per byte, so the highest lane index wins on overlapping bytes.
- Each queue entry holds {is_store, size, data, cnt}.
  - cnt is loaded with LATENCY-1 on accept.
  - Every entry decrements by one each cycle, saturating at 0.
- Latency: d_valid[g] = queue non-empty & head.cnt == 0. A request accepted on the posedge at cycle t produces d_valid at cycle t+LATENCY.
  - Responses are in-order per lane.
  - Back-pressure holds the head stable; later entries keep counting down.
- Simultaneous enqueue and dequeue on one lane: count is unchanged and both take effect.
- inflight is registered from next-state counts, so it is a pure function of state.

Optional Feature:
- Macro: SIMMEM_RESP_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - a_ready[g] is additionally ANDed with lfsr[g % 16], which stress-tests initiator back-pressure.
- Undefined: no LFSR logic; a_ready follows occupancy only.

Decomposition:
- Package sim_mem_pkg: DATA_WIDTH/LOGSIZE_WIDTH defaults, BO constant, resp_entry_t struct {is_store, size, data, cnt}, byte-mask function (offset, size) -> mask.
- Sub-module sim_mem_resp_queue: one per lane, instanced in a generate loop. It is a circular buffer with head/tail pointers, count, per-entry saturating countdown, and head-ready output.
- The top level holds the RAM, mask/merge logic, lane-ordered write arbitration, inflight and the optional LFSR.

Test Plan:
- Single load latency: store 0x1122334455667788 to addr 0x40 on lane0 at t0, then load 0x40 at t1 with size 3 -> d_valid lane0 at t0+4 (store, d_data 0) and at t1+4 with d_data 0x1122334455667788.
- Sub-word store: size 0 store of data 0xAB<<16 to addr 0x42, then load 0x40 -> returned word equals the prior word with byte 2 replaced by 0xAB.
- Queue full: d_ready=0, lane1 issues 5 back-to-back loads -> 4 accepted, a_ready=0 from the cycle after the 4th accept. Raising d_ready drains all 4 in order, one per cycle; a_ready reasserts the cycle after the first d-fire.
- Collision: lanes 0 and 3 store 0x1 and 0x3 to addr 0x80 in the same cycle; lane2 loads 0x80 in that same cycle -> lane2 returns the old value; a later load returns 0x3.
- Reset mid-flight: 3 loads queued on lane2, reset pulsed for 1 cycle -> no d_valid afterwards, inflight=0 on the cycle after reset.
- inflight: one load on lane0 -> inflight=1 from the cycle after accept through the d-fire cycle, and 0 on the following cycle.
